// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one sequential ALU
// between two requesters, with a watchdog on every issued operation.
module alu_arbiter #(
    parameter int W       = 4,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           req0,
    input  logic [1:0]     op0,
    input  logic [W-1:0]   a0,
    input  logic [W-1:0]   b0,
    output logic           ack0,
    input  logic           req1,
    input  logic [1:0]     op1,
    input  logic [W-1:0]   a1,
    input  logic [W-1:0]   b1,
    output logic           ack1,
    output logic           rvalid0,
    output logic           rvalid1,
    output logic [2*W-1:0] rdata,
    output logic           err,
    output logic           alu_en,
    output logic [1:0]     alu_opcode,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt_q, gnt_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic           rvalid0_q, rvalid0_d;
    logic           rvalid1_q, rvalid1_d;
    logic           err_q, err_d;
    logic           en_q, en_d;
    logic [2*W-1:0] rdata_q, rdata_d;
    logic [1:0]     opc_q, opc_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;

    logic           pick;
    logic           complete;
    logic           abort;

    // Grant choice: 1 selects requester 1; ties go to the one not served last.
    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            (req0 && req1):  pick = ~last_q;
            (req1 && !req0): pick = 1'b1;
            default:         pick = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        err_d     = 1'b0;
        en_d      = 1'b0;
        rdata_d   = rdata_q;
        opc_d     = opc_q;
        a_d       = a_q;
        b_d       = b_q;
        complete  = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d   = pick;
                    last_d  = pick;
                    opc_d   = pick ? op1 : op0;
                    a_d     = pick ? a1 : a0;
                    b_d     = pick ? b1 : b0;
                    ack0_d  = ~pick;
                    ack1_d  = pick;
                    en_d    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A done still high here is left over from the previous op.
                if (cnt_q == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (!alu_done) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (alu_done) begin
                    complete = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (complete || abort) begin
            state_d   = IDLE;
            rvalid0_d = ~gnt_q;
            rvalid1_d = gnt_q;
            err_d     = abort;
            rdata_d   = complete ? alu_result : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            cnt_q     <= 8'd0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            rdata_q   <= '0;
            opc_q     <= 2'd0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err_q     <= err_d;
            en_q      <= en_d;
            rdata_q   <= rdata_d;
            opc_q     <= opc_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign alu_en     = en_q;
    assign alu_opcode = opc_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter
// against a behavioural ALU and a transaction-level arbiter model.
module tb_alu_arbiter;

    localparam int W  = 4;
    localparam int W2 = 2 * W;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          nrst;
    logic          req0, req1;
    logic [1:0]    op0, op1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          ack0, ack1, rvalid0, rvalid1, err;
    logic          alu_en, busy;
    logic [W2-1:0] rdata;
    logic [1:0]    alu_opcode;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_done   = 1'b1;
    logic [W2-1:0] alu_result = '0;

    int tests = 0;
    int fails = 0;
    bit m_last;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .nrst(nrst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err),
        .alu_en(alu_en), .alu_opcode(alu_opcode),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy)
    );

    function automatic logic [W2-1:0] calc(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            2'd0:    return W2'(a) + W2'(b);
            2'd1:    return W2'(a) * W2'(b);
            2'd2:    return (b == 0) ? '1 : W2'(a / b);
            default: return (a < b) ? W2'(1) : W2'(0);
        endcase
    endfunction

    function automatic int lat(input logic [1:0] op);
        return (op == 2'd1 || op == 2'd2) ? 17 : 2;
    endfunction

    // Behavioural ALU: done drops after en, rises lat() edges later.
    int            alu_stale = 0;
    bit            alu_hang  = 1'b0;
    int            rem        = 0;
    int            stale_left = 0;
    logic [W2-1:0] pend_res   = '0;

    always @(posedge clk) begin
        if (alu_en === 1'b1) begin
            pend_res <= calc(alu_opcode, alu_a, alu_b);
            rem      <= lat(alu_opcode) - 1;
            if (alu_stale > 0) stale_left <= alu_stale;
            else alu_done <= 1'b0;
        end else if (stale_left > 0) begin
            stale_left <= stale_left - 1;
            if (stale_left == 1) alu_done <= 1'b0;
        end else if (!alu_done && !alu_hang) begin
            if (rem <= 1) begin
                alu_done   <= 1'b1;
                alu_result <= pend_res;
            end else begin
                rem <= rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (nrst === 1'b1) begin
            tests++;
            if (!$onehot0({ack0, ack1, rvalid0, rvalid1})) begin
                fails++;
                $display("FAIL onehot: ack0/ack1/rv0/rv1=%b%b%b%b required at most one",
                         ack0, ack1, rvalid0, rvalid1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0;
        nrst = 0;
        tick();
        tick();
        tests++;
        if ({ack0, ack1, rvalid0, rvalid1, err, alu_en, busy,
             rdata, alu_opcode, alu_a, alu_b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b err=%b en=%b busy=%b rdata=%h op=%h a=%h b=%h required all 0",
                     ack0, ack1, rvalid0, rvalid1, err, alu_en, busy,
                     rdata, alu_opcode, alu_a, alu_b);
        end
        nrst = 1;
        m_last = 1'b1;
        for (int i = 0; i < 40 && alu_done !== 1'b1; i++) tick();
    endtask

    task automatic test_add_req0();
        int k;
        req0 = 1; op0 = 2'd0; a0 = W'(3); b0 = W'(5);
        tick();
        tests++;
        if (!(ack0 === 1 && ack1 === 0 && alu_en === 1 && busy === 1)) begin
            fails++;
            $display("FAIL add_ack: ack0=%b ack1=%b en=%b busy=%b required 1 0 1 1",
                     ack0, ack1, alu_en, busy);
        end
        tests++;
        if (alu_opcode !== 2'd0 || alu_a !== W'(3) || alu_b !== W'(5)) begin
            fails++;
            $display("FAIL add_operands: op=%0d a=%0d b=%0d required 0 3 5",
                     alu_opcode, alu_a, alu_b);
        end
        req0 = 0;
        k = 0;
        do begin
            tick(); k++;
            if (rvalid0 !== 1) begin
                tests++;
                if (busy !== 1 || alu_en !== 0 || ack0 !== 0) begin
                    fails++;
                    $display("FAIL add_wait: busy=%b en=%b ack0=%b required 1 0 0",
                             busy, alu_en, ack0);
                end
            end
        end while (rvalid0 !== 1 && k < TO + 8);
        tests++;
        if (k != 3) begin
            fails++;
            $display("FAIL add_latency: got %0d required 3", k);
        end
        tests++;
        if (rdata !== W2'(8) || err !== 0 || rvalid1 !== 0) begin
            fails++;
            $display("FAIL add_result: rdata=%0d err=%b rv1=%b required 8 0 0",
                     rdata, err, rvalid1);
        end
        tick();
        tests++;
        if (busy !== 0 || rvalid0 !== 0 || rdata !== W2'(8)) begin
            fails++;
            $display("FAIL add_idle: busy=%b rv0=%b rdata=%0d required 0 0 8",
                     busy, rvalid0, rdata);
        end
    endtask

    task automatic test_mul_req1();
        int k;
        req1 = 1; op1 = 2'd1; a1 = W'(7); b1 = W'(6);
        tick();
        tests++;
        if (ack1 !== 1 || ack0 !== 0 || alu_en !== 1 || alu_opcode !== 2'd1) begin
            fails++;
            $display("FAIL mul_ack: ack1=%b ack0=%b en=%b op=%0d required 1 0 1 1",
                     ack1, ack0, alu_en, alu_opcode);
        end
        req1 = 0;
        k = 0;
        do begin
            tick(); k++;
            tests++;
            if (ack0 !== 0 || rvalid0 !== 0) begin
                fails++;
                $display("FAIL mul_quiet0: ack0=%b rv0=%b required 0 0", ack0, rvalid0);
            end
        end while (rvalid1 !== 1 && k < TO + 8);
        tests++;
        if (k != 18) begin
            fails++;
            $display("FAIL mul_latency: got %0d required 18", k);
        end
        tests++;
        if (rdata !== W2'(42) || err !== 0) begin
            fails++;
            $display("FAIL mul_result: rdata=%0d err=%b required 42 0", rdata, err);
        end
    endtask

    task automatic test_round_robin();
        int ack_c[3];
        int ack_w[3];
        int n, c, rv0_c, rv1_c;
        logic [1:0] o0, o1;
        test_reset();
        for (int i = 0; i < 3; i++) begin ack_c[i] = -1; ack_w[i] = -1; end
        op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
        op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        o0 = op0; o1 = op1;
        req0 = 1; req1 = 1;
        n = 0; c = 0; rv0_c = -1; rv1_c = -1;
        while (n < 3 && c < 120) begin
            tick(); c++;
            if (ack0 === 1 || ack1 === 1) begin
                ack_c[n] = c;
                ack_w[n] = (ack1 === 1) ? 1 : 0;
                n++;
                if (ack0 === 1) req0 = 0; else req1 = 0;
            end
            if (rvalid0 === 1) begin
                rv0_c = c;
                tests++;
                if (rdata !== calc(op0, a0, b0)) begin
                    fails++;
                    $display("FAIL rr_data0: got %h required %h", rdata, calc(op0, a0, b0));
                end
            end
            if (rvalid1 === 1) begin
                rv1_c = c;
                tests++;
                if (rdata !== calc(op1, a1, b1)) begin
                    fails++;
                    $display("FAIL rr_data1: got %h required %h", rdata, calc(op1, a1, b1));
                end
                op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
                req0 = 1; req1 = 1;
            end
        end
        tests++;
        if (ack_w[0] != 0 || ack_c[0] != 1) begin
            fails++;
            $display("FAIL rr_first: who=%0d cycle=%0d required 0 1", ack_w[0], ack_c[0]);
        end
        tests++;
        if (rv0_c != 1 + lat(o0) + 1) begin
            fails++;
            $display("FAIL rr_rv0_time: got %0d required %0d", rv0_c, 2 + lat(o0));
        end
        tests++;
        if (ack_w[1] != 1 || ack_c[1] != rv0_c + 1) begin
            fails++;
            $display("FAIL rr_second: who=%0d cycle=%0d required 1 %0d",
                     ack_w[1], ack_c[1], rv0_c + 1);
        end
        tests++;
        if (rv1_c != ack_c[1] + lat(o1) + 1) begin
            fails++;
            $display("FAIL rr_rv1_time: got %0d required %0d", rv1_c, ack_c[1] + lat(o1) + 1);
        end
        tests++;
        if (ack_w[2] != 0 || ack_c[2] != rv1_c + 1) begin
            fails++;
            $display("FAIL rr_third: who=%0d cycle=%0d required 0 %0d",
                     ack_w[2], ack_c[2], rv1_c + 1);
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_stale_done();
        int k;
        test_reset();
        alu_stale = 5;
        req0 = 1; op0 = 2'd0; a0 = W'(2); b0 = W'(9);
        tick();
        tests++;
        if (ack0 !== 1) begin
            fails++;
            $display("FAIL stale_ack: ack0=%b required 1", ack0);
        end
        req0 = 0;
        k = 0;
        do begin
            tick(); k++;
        end while (rvalid0 !== 1 && k < TO + 8);
        tests++;
        if (k != 5 + 2 + 1) begin
            fails++;
            $display("FAIL stale_latency: got %0d required 8", k);
        end
        tests++;
        if (rdata !== W2'(11) || err !== 0) begin
            fails++;
            $display("FAIL stale_result: rdata=%0d err=%b required 11 0", rdata, err);
        end
        alu_stale = 0;
    endtask

    task automatic test_timeout();
        int k;
        logic [1:0] o;
        logic [W-1:0] a, b;
        alu_hang = 1'b1;
        req0 = 1; op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
        tick();
        tests++;
        if (ack0 !== 1 || alu_en !== 1) begin
            fails++;
            $display("FAIL to_ack: ack0=%b en=%b required 1 1", ack0, alu_en);
        end
        req0 = 0;
        k = 0;
        do begin
            tick(); k++;
        end while (rvalid0 !== 1 && k < TO + 8);
        tests++;
        if (k != TO) begin
            fails++;
            $display("FAIL to_latency: got %0d required %0d", k, TO);
        end
        tests++;
        if (err !== 1 || rdata !== '0) begin
            fails++;
            $display("FAIL to_abort: err=%b rdata=%h required 1 0", err, rdata);
        end
        tick();
        tests++;
        if (err !== 0 || rvalid0 !== 0 || busy !== 0) begin
            fails++;
            $display("FAIL to_clear: err=%b rv0=%b busy=%b required 0 0 0", err, rvalid0, busy);
        end
        alu_hang = 1'b0;
        o = 2'($urandom); a = W'($urandom); b = W'($urandom);
        req1 = 1; op1 = o; a1 = a; b1 = b;
        tick();
        tests++;
        if (ack1 !== 1) begin
            fails++;
            $display("FAIL to_next_ack: ack1=%b required 1", ack1);
        end
        req1 = 0;
        k = 0;
        do begin
            tick(); k++;
        end while (rvalid1 !== 1 && k < TO + 8);
        tests++;
        if (k != lat(o) + 1 || rdata !== calc(o, a, b) || err !== 0) begin
            fails++;
            $display("FAIL to_next_op: lat=%0d rdata=%h err=%b required %0d %h 0",
                     k, rdata, err, lat(o) + 1, calc(o, a, b));
        end
    endtask

    task automatic test_reset_midop();
        int seen;
        req1 = 1; op1 = 2'd1; a1 = W'($urandom); b1 = W'($urandom);
        tick();
        tests++;
        if (ack1 !== 1) begin
            fails++;
            $display("FAIL mid_ack: ack1=%b required 1", ack1);
        end
        req1 = 0;
        repeat (6) tick();
        nrst = 0;
        tick();
        tests++;
        if ({ack0, ack1, rvalid0, rvalid1, err, alu_en, busy,
             rdata, alu_opcode, alu_a, alu_b} !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: busy=%b op=%h a=%h b=%h rdata=%h required all 0",
                     busy, alu_opcode, alu_a, alu_b, rdata);
        end
        nrst = 1;
        seen = 0;
        repeat (25) begin
            tick();
            if (rvalid0 !== 0 || rvalid1 !== 0 || err !== 0) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_no_rvalid: got %0d cycles with rvalid/err required 0", seen);
        end
        req1 = 1; op1 = 2'($urandom);
        req0 = 1; op0 = 2'($urandom);
        tick();
        tests++;
        if (ack0 !== 1 || ack1 !== 0) begin
            fails++;
            $display("FAIL mid_priority: ack0=%b ack1=%b required 1 0", ack0, ack1);
        end
        req0 = 0; req1 = 0;
    endtask

    task automatic test_random_traffic(input int ncyc, input int req_pct,
                                       input int keep_pct);
        bit            pend;
        int            g, rv_at, c;
        logic [1:0]    exp_ack, exp_rv, eo;
        logic [W-1:0]  ea, eb;
        logic [W2-1:0] exp_d;
        test_reset();
        pend = 0; c = 0; g = 0; rv_at = -1;
        eo = '0; ea = '0; eb = '0; exp_d = '0;
        for (int i = 0; i < ncyc; i++) begin
            exp_ack = 2'b00;
            if (!pend && (req0 || req1)) begin
                g = (req0 && req1) ? (m_last ? 0 : 1) : (req1 ? 1 : 0);
                eo = g ? op1 : op0;
                ea = g ? a1 : a0;
                eb = g ? b1 : b0;
                exp_ack = g ? 2'b10 : 2'b01;
                m_last = g[0];
                pend = 1;
                rv_at = c + 1 + lat(eo) + 1;
                exp_d = calc(eo, ea, eb);
            end
            tick(); c++;
            tests++;
            if ({ack1, ack0} !== exp_ack) begin
                fails++;
                $display("FAIL rnd_ack: cycle %0d got %b required %b", c, {ack1, ack0}, exp_ack);
            end
            if (exp_ack != 2'b00) begin
                tests++;
                if (alu_en !== 1 || alu_opcode !== eo || alu_a !== ea || alu_b !== eb) begin
                    fails++;
                    $display("FAIL rnd_issue: en=%b op=%h a=%h b=%h required 1 %h %h %h",
                             alu_en, alu_opcode, alu_a, alu_b, eo, ea, eb);
                end
            end
            exp_rv = (pend && c == rv_at) ? (g ? 2'b10 : 2'b01) : 2'b00;
            tests++;
            if ({rvalid1, rvalid0} !== exp_rv) begin
                fails++;
                $display("FAIL rnd_rvalid: cycle %0d got %b required %b",
                         c, {rvalid1, rvalid0}, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                pend = 0;
                tests++;
                if (rdata !== exp_d || err !== 0) begin
                    fails++;
                    $display("FAIL rnd_data: rdata=%h err=%b required %h 0", rdata, err, exp_d);
                end
            end
            if (exp_ack[0]) begin
                if ($urandom_range(99) < keep_pct) begin
                    op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
                end else req0 = 0;
            end else if (!req0 && $urandom_range(99) < req_pct) begin
                req0 = 1; op0 = 2'($urandom); a0 = W'($urandom); b0 = W'($urandom);
            end
            if (exp_ack[1]) begin
                if ($urandom_range(99) < keep_pct) begin
                    op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
                end else req1 = 0;
            end else if (!req1 && $urandom_range(99) < req_pct) begin
                req1 = 1; op1 = 2'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        nrst = 0;
        req0 = 0; op0 = '0; a0 = '0; b0 = '0;
        req1 = 0; op1 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_add_req0();
        test_mul_req1();
        test_round_robin();
        test_stale_done();
        test_timeout();
        test_reset_midop();
        test_random_traffic(400, 40, 30);
        test_random_traffic(400, 100, 50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
